// File: rtl/osc_bank.sv
// Time-multiplexed oscillator bank: one phase-accumulator datapath steps VOICES
// voices per sample tick, emitting serial per-voice samples and their sum.
module osc_bank #(
  parameter int VOICES   = 4,
  parameter int BITDEPTH = 14,
  parameter int ACCBITS  = 16,
  parameter int VW       = $clog2(VOICES),
  parameter int MIXBITS  = BITDEPTH + $clog2(VOICES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               cfg_we,
  input  logic [VW-1:0]      cfg_voice,
  input  logic [1:0]         cfg_addr,
  input  logic [15:0]        cfg_data,
  output logic               out_valid,
  output logic [VW-1:0]      out_voice,
  output logic [BITDEPTH-1:0] out_sample,
  output logic               mix_valid,
  output logic [MIXBITS-1:0] mix_out,
  output logic               busy,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state;
  logic [VW-1:0]         vidx;
  logic [MIXBITS-1:0]    acc;

  logic [ACCBITS-1:0]    sh_inc  [VOICES];
  logic [ACCBITS-1:0]    nx_inc  [VOICES];
  logic [ACCBITS-1:0]    act_inc [VOICES];
  logic [4:0]            sh_ctl  [VOICES];
  logic [4:0]            nx_ctl  [VOICES];
  logic [4:0]            act_ctl [VOICES];
  logic [7:0]            sh_pw   [VOICES];
  logic [7:0]            nx_pw   [VOICES];
  logic [7:0]            act_pw  [VOICES];
  logic [ACCBITS-1:0]    phase   [VOICES];
  logic [VOICES-1:0]     sub_q;
  logic [VOICES-1:0]     wrap_q;

  // Shadow set including this cycle's write, so a write coinciding with an
  // accepted tick lands in that frame.
  always_comb begin
    for (int unsigned i = 0; i < VOICES; i++) begin
      nx_inc[i] = sh_inc[i];
      nx_ctl[i] = sh_ctl[i];
      nx_pw[i]  = sh_pw[i];
    end
    if (cfg_we) begin
      case (cfg_addr)
        2'd0:    nx_inc[cfg_voice] = ACCBITS'(cfg_data);
        2'd1:    nx_ctl[cfg_voice] = cfg_data[4:0];
        2'd2:    nx_pw[cfg_voice]  = cfg_data[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < VOICES; i++) begin
        sh_inc[i] <= '0;
        sh_ctl[i] <= '0;
        sh_pw[i]  <= 8'h80;
      end
    end else begin
      sh_inc <= nx_inc;
      sh_ctl <= nx_ctl;
      sh_pw  <= nx_pw;
    end
  end

  logic [VW-1:0]         pidx;
  logic [ACCBITS:0]      sum;
  logic [ACCBITS-1:0]    new_ph;
  logic                  new_wrap;
  logic                  new_sub;
  logic                  v_en;
  logic                  do_sync;
  logic [BITDEPTH-1:0]   p;
  logic [BITDEPTH-1:0]   tri_w;
  logic [BITDEPTH-1:0]   wave_v;
  logic [BITDEPTH-1:0]   smp;

  // Sync only counts when the previous voice is enabled, i.e. its wrap flag
  // was refreshed in this frame rather than held from an earlier one.
  always_comb begin
    pidx     = vidx - VW'(1);
    v_en     = act_ctl[vidx][3];
    sum      = {1'b0, phase[vidx]} + {1'b0, act_inc[vidx]};
    do_sync  = act_ctl[vidx][4] && (vidx != '0) && wrap_q[pidx] && act_ctl[pidx][3];
    new_ph   = do_sync ? '0 : sum[ACCBITS-1:0];
    new_wrap = do_sync | sum[ACCBITS];
    new_sub  = sub_q[vidx] ^ new_wrap;
    p        = new_ph[ACCBITS-1 -: BITDEPTH];
    tri_w    = p[BITDEPTH-1] ? ~{p[BITDEPTH-2:0], 1'b0} : {p[BITDEPTH-2:0], 1'b0};
    case (act_ctl[vidx][2:0])
      3'd0:    wave_v = p;
      3'd1:    wave_v = tri_w;
      3'd2:    wave_v = (p[BITDEPTH-1 -: 8] < act_pw[vidx]) ? '1 : '0;
      3'd3:    wave_v = new_sub ? '1 : '0;
      default: wave_v = '0;
    endcase
    smp = v_en ? wave_v : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      vidx       <= '0;
      acc        <= '0;
      sub_q      <= '0;
      wrap_q     <= '0;
      out_valid  <= 1'b0;
      out_voice  <= '0;
      out_sample <= '0;
      mix_valid  <= 1'b0;
      mix_out    <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int unsigned i = 0; i < VOICES; i++) begin
        phase[i]   <= '0;
        act_inc[i] <= '0;
        act_ctl[i] <= '0;
        act_pw[i]  <= 8'h80;
      end
    end else begin
      out_valid <= 1'b0;
      mix_valid <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (sample_tick) begin
            if (busy) begin
              overrun <= 1'b1;
            end else begin
              busy    <= 1'b1;
              act_inc <= nx_inc;
              act_ctl <= nx_ctl;
              act_pw  <= nx_pw;
              acc     <= '0;
              vidx    <= '0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          if (sample_tick) overrun <= 1'b1;
          if (v_en) begin
            phase[vidx]  <= new_ph;
            sub_q[vidx]  <= new_sub;
            wrap_q[vidx] <= new_wrap;
          end
          out_valid  <= 1'b1;
          out_voice  <= vidx;
          out_sample <= smp;
          acc        <= acc + MIXBITS'(smp);
          if (vidx == VW'(VOICES - 1)) state <= FLUSH;
          else                         vidx  <= vidx + VW'(1);
        end
        FLUSH: begin
          if (sample_tick) overrun <= 1'b1;
          mix_valid <= 1'b1;
          mix_out   <= acc;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_bank.sv
// Self-checking bench for osc_bank: cycle-level behavioural model compared on
// every cycle, plus directed literal expectations.
module tb_osc_bank;

  localparam int V   = 4;
  localparam int BD  = 14;
  localparam int ACC = 16;
  localparam int VW  = 2;
  localparam int MB  = 16;
  localparam int MAXV = (1 << BD) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sample_tick = 1'b0;
  logic          cfg_we = 1'b0;
  logic [VW-1:0] cfg_voice = '0;
  logic [1:0]    cfg_addr = '0;
  logic [15:0]   cfg_data = '0;
  logic          out_valid;
  logic [VW-1:0] out_voice;
  logic [BD-1:0] out_sample;
  logic          mix_valid;
  logic [MB-1:0] mix_out;
  logic          busy;
  logic          overrun;

  osc_bank #(.VOICES(V), .BITDEPTH(BD), .ACCBITS(ACC)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_voice(out_voice), .out_sample(out_sample),
    .mix_valid(mix_valid), .mix_out(mix_out), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_sh_inc[V], m_sh_ctl[V], m_sh_pw[V];
  int m_inc[V], m_ctl[V], m_pw[V];
  int m_phase[V], m_sub[V];
  int fs[V];
  int fmix;
  int a = -1000;
  int pcount = 0;
  int m_overrun = 0;
  int m_last_voice = 0, m_last_sample = 0, m_mix = 0;

  task automatic model_reset();
    for (int k = 0; k < V; k++) begin
      m_sh_inc[k] = 0; m_sh_ctl[k] = 0; m_sh_pw[k] = 'h80;
      m_inc[k] = 0; m_ctl[k] = 0; m_pw[k] = 'h80;
      m_phase[k] = 0; m_sub[k] = 0; fs[k] = 0;
    end
    fmix = 0; a = -1000; m_overrun = 0;
    m_last_voice = 0; m_last_sample = 0; m_mix = 0;
  endtask

  task automatic model_frame();
    int wrapped[V];
    fmix = 0;
    for (int k = 0; k < V; k++) begin
      int s, w, p, v, smp;
      wrapped[k] = 0;
      smp = 0;
      if ((m_ctl[k] >> 3) & 1) begin
        s = m_phase[k] + m_inc[k];
        w = (s >= (1 << ACC)) ? 1 : 0;
        if (((m_ctl[k] >> 4) & 1) && k > 0 && wrapped[k-1] == 1) begin
          m_phase[k] = 0;
          w = 1;
        end else begin
          m_phase[k] = s % (1 << ACC);
        end
        if (w == 1) m_sub[k] = 1 - m_sub[k];
        wrapped[k] = w;
        p = m_phase[k] >> (ACC - BD);
        case (m_ctl[k] & 7)
          0: smp = p;
          1: begin
            v = (2 * p) % (1 << BD);
            smp = (p >= (1 << (BD - 1))) ? MAXV - v : v;
          end
          2: smp = ((p >> (BD - 8)) < m_pw[k]) ? MAXV : 0;
          3: smp = m_sub[k] ? MAXV : 0;
          default: smp = 0;
        endcase
      end
      fs[k] = smp;
      fmix += smp;
    end
  endtask

  always @(posedge clk) begin
    int jcur;
    jcur = pcount - a + 1;
    pcount++;
    if (!rst) begin
      model_reset();
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: m_sh_inc[cfg_voice] = int'(cfg_data) % (1 << ACC);
          2'd1: m_sh_ctl[cfg_voice] = int'(cfg_data) & 31;
          2'd2: m_sh_pw[cfg_voice]  = int'(cfg_data) & 255;
          default: ;
        endcase
      end
      if (sample_tick) begin
        if (jcur >= 1 && jcur <= V + 2) begin
          m_overrun = 1;
        end else begin
          m_inc = m_sh_inc; m_ctl = m_sh_ctl; m_pw = m_sh_pw;
          model_frame();
          a = pcount;
        end
      end
    end
  end

  int cap[V];
  int cap_mix = 0;
  int nv = 0, nm = 0;

  always @(negedge clk) begin
    if (pcount > 0) begin
      int j, ev, emv, eb;
      j = pcount - a + 1;
      ev = 0; emv = 0;
      if (j >= 2 && j <= V + 1) begin
        ev = 1; m_last_voice = j - 2; m_last_sample = fs[j-2];
      end
      if (j == V + 2) begin
        emv = 1; m_mix = fmix;
      end
      eb = (j >= 1 && j <= V + 2) ? 1 : 0;
      chk("out_valid", out_valid, ev);
      chk("out_voice", out_voice, m_last_voice);
      chk("out_sample", out_sample, m_last_sample);
      chk("mix_valid", mix_valid, emv);
      chk("mix_out", mix_out, m_mix);
      chk("busy", busy, eb);
      chk("overrun", overrun, m_overrun);
      if (out_valid) begin cap[out_voice] = int'(out_sample); nv++; end
      if (mix_valid) begin cap_mix = int'(mix_out); nm++; end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input int v, input int ad, input int d);
    cfg_we = 1'b1; cfg_voice = VW'(v); cfg_addr = 2'(ad); cfg_data = 16'(d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic frame();
    tick();
    idle(V + 4);
  endtask

  initial begin
    int e_tri[4]  = '{'h2000, 'h3FFF, 'h1FFF, 'h0000};
    int e_pul[4]  = '{0, 0, 0, 'h3FFF};
    int e_sync[4] = '{'h0C00, 0, 'h0C00, 0};
    int e_sub[5]  = '{0, 'h3FFF, 'h3FFF, 0, 0};

    idle(3);
    rst = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_out_sample", out_sample, 0);
    chk("reset_mix_out", mix_out, 0);
    chk("reset_overrun", overrun, 0);

    // saw
    wr(0, 0, 'h0400); wr(0, 1, 'h08);
    frame(); chk("saw_tick1", cap[0], 'h0100);
    frame(); chk("saw_tick2", cap[0], 'h0200);
    for (int n = 3; n <= 64; n++) frame();
    chk("saw_tick64", cap[0], 'h0000);

    // triangle
    do_reset(); wr(0, 0, 'h4000); wr(0, 1, 'h09);
    for (int n = 0; n < 4; n++) begin frame(); chk("tri", cap[0], e_tri[n]); end

    // pulse
    do_reset(); wr(0, 0, 'h4000); wr(0, 2, 'h40); wr(0, 1, 'h0A);
    for (int n = 0; n < 4; n++) begin frame(); chk("pulse", cap[0], e_pul[n]); end

    // hard sync
    do_reset(); wr(0, 0, 'h8000); wr(0, 1, 'h08); wr(1, 0, 'h3000); wr(1, 1, 'h18);
    for (int n = 0; n < 4; n++) begin
      frame(); chk("sync_v1", cap[1], e_sync[n]);
      if (n == 0) chk("sync_mix", cap_mix, 'h2C00);
    end

    // sub-octave
    do_reset(); wr(2, 0, 'h8000); wr(2, 1, 'h0B);
    for (int n = 0; n < 5; n++) begin frame(); chk("sub", cap[2], e_sub[n]); end

    // disabled voice holds phase
    do_reset(); wr(3, 0, 'h1000); wr(3, 1, 'h08);
    frame(); chk("hold_before", cap[3], 'h0400);
    wr(3, 1, 'h00);
    frame(); chk("hold_off1", cap[3], 0);
    frame(); chk("hold_off2", cap[3], 0);
    wr(3, 1, 'h08);
    frame(); chk("hold_after", cap[3], 'h0800);

    // overrun: second tick three cycles after the first
    do_reset(); wr(0, 0, 'h0400); wr(0, 1, 'h08);
    nv = 0; nm = 0;
    tick(); idle(2); tick(); idle(V + 4);
    chk("ovr_valid_count", nv, V);
    chk("ovr_mix_count", nm, 1);
    chk("ovr_flag", overrun, 1);
    frame();
    chk("ovr_sticky", overrun, 1);

    // write during RUN applies to next frame
    do_reset(); wr(0, 0, 'h0400); wr(0, 1, 'h08);
    tick(); wr(0, 0, 'h0800); idle(V + 4);
    chk("run_wr_old", cap[0], 'h0100);
    frame();
    chk("run_wr_new", cap[0], 'h0300);

    // reset mid-frame
    do_reset(); wr(0, 0, 'h0400); wr(0, 1, 'h08);
    frame(); frame();
    nm = 0;
    tick(); idle(1);
    rst = 1'b0; @(posedge clk); #1; rst = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_mix", mix_out, 0);
    idle(V + 4);
    chk("midrst_no_mix", nm, 0);
    wr(0, 0, 'h0400); wr(0, 1, 'h08);
    frame(); chk("midrst_restart", cap[0], 'h0100);

    // randomized traffic
    for (int it = 0; it < 2000; it++) begin
      cfg_we = ($urandom_range(0, 9) < 3);
      cfg_voice = VW'($urandom_range(0, V - 1));
      cfg_addr = 2'($urandom_range(0, 3));
      case (cfg_addr)
        2'd0: cfg_data = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 'h0800));
        2'd1: cfg_data = 16'($urandom_range(0, 31) | (($urandom_range(0, 3) != 0) ? 8 : 0));
        default: cfg_data = 16'($urandom);
      endcase
      sample_tick = ($urandom_range(0, 9) < 3);
      rst = ($urandom_range(0, 199) != 0);
      @(posedge clk); #1;
    end
    cfg_we = 1'b0; sample_tick = 1'b0; rst = 1'b1;
    idle(V + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
